// File: rtl/dspl_mux_drv.sv
// Multiplexed 7-segment display driver: time-sliced anode scan with per-digit
// enable, blink and global PWM brightness; cathodes decoded from the held digit.
module dspl_mux_drv #(
  parameter int N_DIG        = 8,
  parameter int TICK_COUNT   = 100000,
  parameter int BRT_W        = 3,
  parameter int BLINK_FRAMES = 250
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [6*N_DIG-1:0]   digits,
  input  logic [N_DIG-1:0]     blink_mask,
  input  logic [BRT_W-1:0]     brightness,
  output logic [N_DIG-1:0]     an,
  output logic [7:0]           dec_cat,
  output logic                 frame_done
);

  localparam int SW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam int PW = $clog2(TICK_COUNT);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_COUNT - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(N_DIG - 1);
  localparam logic [FW-1:0] FRM_LAST  = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0]    presc;
  logic [SW-1:0]    slot;
  logic [SW-1:0]    held_slot;
  logic [5:0]       held_dig;
  logic             held_blk;
  logic [FW-1:0]    frm_cnt;
  logic             blink_phase;
  logic [BRT_W-1:0] pwm_cnt;

  logic             tick;
  logic             wrap;
  logic             pwm_on;
  logic             visible;
  logic [5:0]       sel_dig;
  logic             sel_blk;
  logic [N_DIG-1:0] an_nxt;
  logic [6:0]       seg;

  assign tick    = (presc == PRE_LAST);
  assign wrap    = tick && (slot == SLOT_LAST);
  assign pwm_on  = (pwm_cnt <= brightness);
  // held blink bit only darkens the digit during the dark half of the blink period
  assign visible = held_dig[5] && !(held_blk && blink_phase) && pwm_on;

  always_comb begin
    sel_dig = '0;
    sel_blk = 1'b0;
    for (int unsigned i = 0; i < N_DIG; i++) begin
      if (slot == SW'(i)) begin
        sel_dig = digits[6*i +: 6];
        sel_blk = blink_mask[i];
      end
    end
  end

  always_comb begin
    an_nxt = '1;
    for (int unsigned k = 0; k < N_DIG; k++) begin
      if (visible && (held_slot == SW'(k)))
        an_nxt[k] = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      presc       <= '0;
      slot        <= '0;
      held_slot   <= '0;
      held_dig    <= '0;
      held_blk    <= 1'b0;
      frm_cnt     <= '0;
      blink_phase <= 1'b0;
      pwm_cnt     <= '0;
      an          <= '1;
      frame_done  <= 1'b0;
    end else begin
      pwm_cnt    <= pwm_cnt + 1'b1;
      an         <= an_nxt;
      frame_done <= wrap;
      presc      <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        held_slot <= slot;
        held_dig  <= sel_dig;
        held_blk  <= sel_blk;
        slot      <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
      end
      if (wrap) begin
        if (frm_cnt == FRM_LAST) begin
          frm_cnt     <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frm_cnt <= frm_cnt + 1'b1;
        end
      end
    end
  end

  // segments ordered g..a, active low
  always_comb begin
    case (held_dig[4:1])
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
  end

  assign dec_cat = {seg, ~held_dig[0]};

endmodule
